// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: FSM encoding, parity sense and the supported oversampling ratios.
// Pure declarations; no timing or flow control.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b110,
        ST_STOP   = 3'b010
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;

    // Any ratio other than 16 or 32 runs the frame at 8x.
    function automatic int presc_or_default(input int p);
        return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receive result bus: payload, one-cycle status pulses and busy flag.
// No handshake; the consumer must take each pulse in the cycle it appears.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (output P_DATA, data_valid, par_err, stp_err, busy);
    modport slave  (input  P_DATA, data_valid, par_err, stp_err, busy);
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and 3-sample majority vote.
// rx_s lags RX_IN by 2 cycles; bit_val is valid from edge P/2+3 onward; no backpressure.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               rx_s,
    output logic               bit_val,
    output logic               bit_end
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] TWO = PRESC_W'(2);

    logic               sync1;
    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [2:0]         smp;

    assign half    = presc >> 1;
    assign bit_end = run && (edge_cnt == presc - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            smp      <= '0;
            bit_val  <= 1'b0;
        end else if (!run || bit_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + ONE;
            if (edge_cnt == half - ONE) smp[0] <= rx_s;
            if (edge_cnt == half)       smp[1] <= rx_s;
            if (edge_cnt == half + ONE) smp[2] <= rx_s;
            if (edge_cnt == half + TWO)
                bit_val <= (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserializer, parity and stop checks.
// Result pulses appear 3 cycles after the stop bit ends on RX_IN; no backpressure.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    uart_rx_ctrl_if.master     rx
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_t               state_q, state_d;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [PRESC_W-1:0]      presc_q;
    logic                    par_en_q, par_typ_q, perr_q;
    logic                    rx_s, bit_val, bit_end;
    logic                    start_det, done;

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .clk     (CLK),
        .rst_n   (RST),
        .rx_in   (RX_IN),
        .run     (state_q != ST_IDLE),
        .presc   (presc_q),
        .rx_s    (rx_s),
        .bit_val (bit_val),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        start_det = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: if (!rx_s) begin
                state_d   = ST_START;
                start_det = 1'b1;
            end
            ST_START:  if (bit_end) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && bit_cnt_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP: if (bit_end) begin
                done = 1'b1;
                // A good stop followed by an immediate low is the next start bit; take it
                // now so back-to-back frames keep the same sampling phase.
                if (bit_val && !rx_s) begin
                    state_d   = ST_START;
                    start_det = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            presc_q       <= PRESC_W'(PRESC_8);
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            perr_q        <= 1'b0;
            rx.P_DATA     <= '0;
            rx.data_valid <= 1'b0;
            rx.par_err    <= 1'b0;
            rx.stp_err    <= 1'b0;
            rx.busy       <= 1'b0;
        end else begin
            state_q <= state_d;
            rx.busy <= (state_d != ST_IDLE);
            if (start_det) begin
                presc_q   <= PRESC_W'(presc_or_default(int'(Prescale)));
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                perr_q    <= 1'b0;
            end
            if (state_q == ST_START && bit_end)
                bit_cnt_q <= '0;
            if (state_q == ST_DATA && bit_end) begin
                shift_q   <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (state_q == ST_PARITY && bit_end)
                perr_q <= bit_val != ((par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q);
            rx.data_valid <= done && bit_val && !perr_q;
            rx.par_err    <= done && perr_q;
            rx.stp_err    <= done && !bit_val;
            if (done && bit_val && !perr_q)
                rx.P_DATA <= shift_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) rx_bus ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESC_W(6)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .Prescale (Prescale),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .rx       (rx_bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int         cyc;
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } evt_t;
    evt_t evq[$];

    always @(negedge CLK)
        if (rx_bus.data_valid || rx_bus.par_err || rx_bus.stp_err)
            evq.push_back('{cyc, rx_bus.data_valid, rx_bus.par_err, rx_bus.stp_err, rx_bus.P_DATA});

    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_bit(input int p, input logic b, input bit noisy);
        for (int i = 0; i < p; i++) begin
            @(negedge CLK);
            RX_IN = (noisy && i == p / 2) ? ~b : b;
        end
    endtask

    task automatic send_frame(input int p, input logic [7:0] d, input bit pen,
                              input logic pbit, input logic sbit, input bit noisy);
        send_bit(p, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(p, d[i], noisy && i == 3);
        if (pen) send_bit(p, pbit, 1'b0);
        send_bit(p, sbit, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    function automatic logic good_parity(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return odd ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    endfunction

    // Frame-level expectation: exactly one result pulse set, P_DATA holds the last good payload.
    task automatic expect_frame(input string tag, input logic [7:0] d, input bit pen,
                                input logic ptyp, input logic pbit, input logic sbit);
        logic perr, serr;
        evt_t e;
        perr = pen && (pbit != good_parity(d, ptyp));
        serr = !sbit;
        if (!perr && !serr) last_good = d;
        check($sformatf("%s.events", tag), evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check($sformatf("%s.data_valid", tag), e.dv, !perr && !serr);
            check($sformatf("%s.par_err", tag), e.pe, perr);
            check($sformatf("%s.stp_err", tag), e.se, serr);
            check($sformatf("%s.P_DATA", tag), e.d, last_good);
        end
        evq.delete();
        check($sformatf("%s.busy", tag), rx_bus.busy, 1'b0);
    endtask

    task automatic run_frame(input string tag, input int p, input logic [7:0] d, input bit pen,
                             input logic ptyp, input logic pbit, input logic sbit, input bit noisy);
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        send_frame(p, d, pen, pbit, sbit, noisy);
        idle(8);
        expect_frame(tag, d, pen, ptyp, pbit, sbit);
    endtask

    initial begin
        int   p;
        bit   pen;
        logic ptyp, pbit, sbit;
        logic [7:0] d;
        evt_t e0, e1;

        repeat (3) @(negedge CLK);
        check("rst.data_valid", rx_bus.data_valid, 0);
        check("rst.par_err", rx_bus.par_err, 0);
        check("rst.stp_err", rx_bus.stp_err, 0);
        check("rst.busy", rx_bus.busy, 0);
        check("rst.P_DATA", rx_bus.P_DATA, 0);
        RST = 1'b1;
        idle(5);

        run_frame("t1_p8", 8, 8'hA5, 0, PAR_EVEN, 1'b0, 1'b1, 0);
        run_frame("t2_even_ok", 16, 8'h3C, 1, PAR_EVEN, 1'b0, 1'b1, 0);
        run_frame("t2_even_bad", 16, 8'h3C, 1, PAR_EVEN, 1'b1, 1'b1, 0);
        run_frame("t3_stop_err", 32, 8'h00, 1, PAR_ODD, 1'b1, 1'b0, 0);
        idle(40);
        check("t3.busy_idle", rx_bus.busy, 0);

        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        idle(32);
        check("t4.glitch_events", evq.size(), 0);
        check("t4.glitch_busy", rx_bus.busy, 0);
        evq.delete();
        run_frame("t4_after", 16, 8'h5A, 0, PAR_EVEN, 1'b0, 1'b1, 0);

        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        send_frame(8, 8'h01, 0, 1'b0, 1'b1, 0);
        send_frame(8, 8'hFE, 0, 1'b0, 1'b1, 0);
        idle(8);
        check("t5.events", evq.size(), 2);
        if (evq.size() == 2) begin
            e0 = evq.pop_front();
            e1 = evq.pop_front();
            check("t5.dv0", e0.dv, 1);
            check("t5.data0", e0.d, 8'h01);
            check("t5.dv1", e1.dv, 1);
            check("t5.data1", e1.d, 8'hFE);
            check("t5.spacing", e1.cyc - e0.cyc, 80);
            last_good = 8'hFE;
        end
        evq.delete();

        send_bit(8, 1'b0, 1'b0);
        send_bit(8, 1'b1, 1'b0);
        send_bit(8, 1'b0, 1'b0);
        RST = 1'b0;
        idle(3);
        RST = 1'b1;
        idle(100);
        check("t6.no_stale", evq.size(), 0);
        check("t6.busy", rx_bus.busy, 0);
        check("t6.P_DATA_rst", rx_bus.P_DATA, 0);
        evq.delete();
        last_good = 8'h00;
        run_frame("t6_noise", 8, 8'h77, 0, PAR_EVEN, 1'b0, 1'b1, 1);

        // Unsupported ratio falls back to 8x.
        Prescale = 6'd12;
        PAR_EN   = 1'b0;
        send_frame(8, 8'hC3, 0, 1'b0, 1'b1, 0);
        idle(8);
        expect_frame("t7_illegal_p", 8'hC3, 0, PAR_EVEN, 1'b0, 1'b1);

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            d    = 8'($urandom);
            pen  = bit'($urandom_range(1));
            ptyp = logic'($urandom_range(1));
            pbit = good_parity(d, ptyp) ^ ($urandom_range(3) == 0);
            sbit = ($urandom_range(3) != 0);
            run_frame($sformatf("rnd%0d", n), p, d, pen, ptyp, pbit, sbit, bit'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
